// File: rtl/nnrv_mem_arb.sv
// Single-port memory arbiter for the nnrv core: fixed-priority DBG > MEM > IF
// with an IF starvation guard, debug halt and a registered read-return tag.
module nnrv_mem_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_req,
  input  logic                  i_mem_req,
  input  logic                  i_dbg_req,
  input  logic                  i_mem_we,
  input  logic                  i_dbg_we,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  input  logic [3:0]            i_if_mask,
  input  logic [3:0]            i_mem_mask,
  input  logic [3:0]            i_dbg_mask,
  input  logic [XLEN-1:0]       i_mem_wdata,
  input  logic [XLEN-1:0]       i_dbg_wdata,
  input  logic                  i_dbg_halt,
  output logic                  o_if_gnt,
  output logic                  o_mem_gnt,
  output logic                  o_dbg_gnt,
  output logic                  o_if_rvalid,
  output logic                  o_mem_rvalid,
  output logic                  o_dbg_rvalid,
  output logic [XLEN-1:0]       o_rdata,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [3:0]            o_ram_mask,
  output logic [XLEN-1:0]       o_ram_wdata,
  input  logic [XLEN-1:0]       i_ram_rdata
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_MEM  = 2'd2,
    TAG_DBG  = 2'd3
  } rd_tag_e;

  logic [7:0] starve_cnt;
  logic       if_promoted;
  rd_tag_e    rd_tag;
  rd_tag_e    rd_tag_nxt;

  assign if_promoted = (starve_cnt == 8'(STARVE_MAX));

  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // if/else tree can leave it unassigned and infer a latch.
    o_if_gnt  = 1'b0;
    o_mem_gnt = 1'b0;
    o_dbg_gnt = 1'b0;
    if (!i_rst) begin
      if (i_dbg_req) begin
        o_dbg_gnt = 1'b1;
      end else if (!i_dbg_halt) begin
        if (if_promoted) begin
          if (i_if_req)       o_if_gnt  = 1'b1;
          else if (i_mem_req) o_mem_gnt = 1'b1;
        end else begin
          if (i_mem_req)      o_mem_gnt = 1'b1;
          else if (i_if_req)  o_if_gnt  = 1'b1;
        end
      end
    end
  end

  // The winner's command drives the RAM in the grant cycle; idle drives zero.
  always_comb begin
    o_ram_en    = o_if_gnt | o_mem_gnt | o_dbg_gnt;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_mask  = '0;
    o_ram_wdata = '0;
    rd_tag_nxt  = TAG_NONE;
    if (o_dbg_gnt) begin
      o_ram_we    = i_dbg_we;
      o_ram_addr  = i_dbg_addr;
      o_ram_mask  = i_dbg_mask;
      o_ram_wdata = i_dbg_wdata;
      if (!i_dbg_we) rd_tag_nxt = TAG_DBG;
    end else if (o_mem_gnt) begin
      o_ram_we    = i_mem_we;
      o_ram_addr  = i_mem_addr;
      o_ram_mask  = i_mem_mask;
      o_ram_wdata = i_mem_wdata;
      if (!i_mem_we) rd_tag_nxt = TAG_MEM;
    end else if (o_if_gnt) begin
      o_ram_addr  = i_if_addr;
      o_ram_mask  = i_if_mask;
      rd_tag_nxt  = TAG_IF;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_rst) begin
      starve_cnt <= 8'd0;
      rd_tag     <= TAG_NONE;
    end else begin
      rd_tag <= rd_tag_nxt;
      // Halt freezes the count so IF is not promoted by time spent halted.
      if (!i_dbg_halt) begin
        if (!i_if_req || o_if_gnt)
          starve_cnt <= 8'd0;
        else if (!if_promoted)
          starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

  assign o_if_rvalid  = (rd_tag == TAG_IF);
  assign o_mem_rvalid = (rd_tag == TAG_MEM);
  assign o_dbg_rvalid = (rd_tag == TAG_DBG);
  assign o_rdata      = i_ram_rdata;

endmodule

// File: tb/tb_nnrv_mem_arb.sv
// Directed bench for nnrv_mem_arb: grants checked in-cycle against hand
// values, read returns checked by a negedge monitor against a scoreboard queue.
module tb_nnrv_mem_arb;

  localparam int AW = 8;
  localparam int XW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, mem_req, dbg_req, mem_we, dbg_we, dbg_halt;
  logic [AW-1:0] if_addr, mem_addr, dbg_addr;
  logic [3:0]    if_mask, mem_mask, dbg_mask;
  logic [XW-1:0] mem_wdata, dbg_wdata;
  logic          if_gnt, mem_gnt, dbg_gnt;
  logic          if_rvalid, mem_rvalid, dbg_rvalid;
  logic [XW-1:0] rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_mask;
  logic [XW-1:0] ram_wdata;
  logic [XW-1:0] ram_rdata = '0;

  always #5 clk = ~clk;

  nnrv_mem_arb #(.ADDR_WIDTH(AW), .XLEN(XW), .STARVE_MAX(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_mem_req(mem_req), .i_dbg_req(dbg_req),
    .i_mem_we(mem_we), .i_dbg_we(dbg_we),
    .i_if_addr(if_addr), .i_mem_addr(mem_addr), .i_dbg_addr(dbg_addr),
    .i_if_mask(if_mask), .i_mem_mask(mem_mask), .i_dbg_mask(dbg_mask),
    .i_mem_wdata(mem_wdata), .i_dbg_wdata(dbg_wdata),
    .i_dbg_halt(dbg_halt),
    .o_if_gnt(if_gnt), .o_mem_gnt(mem_gnt), .o_dbg_gnt(dbg_gnt),
    .o_if_rvalid(if_rvalid), .o_mem_rvalid(mem_rvalid), .o_dbg_rvalid(dbg_rvalid),
    .o_rdata(rdata),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_mask(ram_mask), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata)
  );

  // Single-port registered-read RAM with byte enables.
  logic [XW-1:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[8'h10] = 32'hDEADBEEF;
    ram[8'h11] = 32'h11111111;
    ram[8'h12] = 32'h22222222;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_mask[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram[ram_addr];
      end
    end
  end

  // Port codes are the rvalid vector {if, mem, dbg}.
  localparam logic [2:0] P_IF  = 3'b100;
  localparam logic [2:0] P_MEM = 3'b010;
  localparam logic [2:0] P_DBG = 3'b001;
  localparam logic [2:0] P_NONE = 3'b000;

  typedef struct {
    logic [2:0]    port;
    logic [XW-1:0] data;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int      checks = 0;
  int      errors = 0;

  task automatic check(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_rd(input logic [2:0] port, input logic [XW-1:0] data);
    rd_exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Inputs are driven 1 time unit after the edge; grants are checked 2 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_gnt(input string name, input logic [2:0] exp);
    #2;
    check({name, " gnt"}, {29'd0, if_gnt, mem_gnt, dbg_gnt}, {29'd0, exp});
    check({name, " ram_en"}, {31'd0, ram_en}, {31'd0, |exp});
  endtask

  task automatic idle();
    if_req = 0; mem_req = 0; dbg_req = 0; mem_we = 0; dbg_we = 0;
  endtask

  // Monitor: every rvalid must match the oldest outstanding expected read.
  always @(negedge clk) begin
    if (if_rvalid | mem_rvalid | dbg_rvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected rvalid", {29'd0, if_rvalid, mem_rvalid, dbg_rvalid}, {29'd0, P_NONE});
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        check("rvalid port", {29'd0, if_rvalid, mem_rvalid, dbg_rvalid}, {29'd0, e.port});
        check("rdata", rdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] starve_seq [10];
    starve_seq = '{P_MEM, P_MEM, P_MEM, P_MEM, P_IF, P_MEM, P_MEM, P_MEM, P_MEM, P_IF};

    rst = 1; dbg_halt = 0;
    if_req = 1; mem_req = 1; dbg_req = 1; mem_we = 0; dbg_we = 0;
    if_addr = 8'h10; mem_addr = 8'h10; dbg_addr = 8'h10;
    if_mask = 4'hF; mem_mask = 4'hF; dbg_mask = 4'hF;
    mem_wdata = '0; dbg_wdata = '0;
    #1;

    // Reset held with every request high.
    for (int i = 0; i < 3; i++) begin
      expect_gnt("reset", P_NONE);
      check("reset rvalid", {29'd0, if_rvalid, mem_rvalid, dbg_rvalid}, 32'd0);
      tick();
    end
    rst = 0;
    expect_gnt("post-reset dbg", P_DBG);
    push_rd(P_DBG, 32'hDEADBEEF);
    tick();
    idle();
    expect_gnt("idle", P_NONE);
    check("idle ram_we", {31'd0, ram_we}, 32'd0);
    tick();

    // IF solo read.
    if_req = 1; if_addr = 8'h10;
    expect_gnt("if solo", P_IF);
    check("if solo ram_addr", {24'd0, ram_addr}, 32'h10);
    push_rd(P_IF, 32'hDEADBEEF);
    tick();
    idle();
    tick();

    // Starvation guard: MEM x4, IF, MEM x4, IF.
    if_req = 1; if_addr = 8'h12; mem_req = 1; mem_we = 0; mem_addr = 8'h11;
    for (int i = 0; i < 10; i++) begin
      expect_gnt($sformatf("starve %0d", i), starve_seq[i]);
      if (starve_seq[i] == P_IF) push_rd(P_IF, 32'h22222222);
      else                       push_rd(P_MEM, 32'h11111111);
      tick();
    end
    idle();
    tick();

    // DBG priority write, then read-after-write by IF.
    if_req = 1; if_addr = 8'h28; mem_req = 1; mem_addr = 8'h11;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h28; dbg_mask = 4'hF; dbg_wdata = 32'h12345678;
    expect_gnt("dbg write", P_DBG);
    check("dbg write ram_we", {31'd0, ram_we}, 32'd1);
    check("dbg write ram_wdata", ram_wdata, 32'h12345678);
    tick();
    dbg_req = 0; dbg_we = 0; mem_req = 0;
    expect_gnt("if raw", P_IF);
    push_rd(P_IF, 32'h12345678);
    tick();
    idle();
    dbg_req = 1; dbg_we = 1; dbg_mask = 4'h1; dbg_wdata = 32'h000000AB;
    expect_gnt("dbg byte write", P_DBG);
    check("dbg byte ram_mask", {28'd0, ram_mask}, 32'h1);
    tick();
    dbg_we = 0; dbg_mask = 4'hF;
    expect_gnt("dbg readback", P_DBG);
    push_rd(P_DBG, 32'h123456AB);
    tick();
    idle();
    tick();

    // Halt: no core grants, DBG still served, starve count frozen.
    dbg_halt = 1; if_req = 1; if_addr = 8'h10; mem_req = 1; mem_we = 0; mem_addr = 8'h12;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h11;
        expect_gnt("halt dbg", P_DBG);
        push_rd(P_DBG, 32'h11111111);
      end else begin
        dbg_req = 0;
        expect_gnt($sformatf("halt %0d", i), P_NONE);
      end
      tick();
    end
    dbg_halt = 0;
    expect_gnt("halt release", P_MEM);
    push_rd(P_MEM, 32'h22222222);
    tick();
    // Halt right after a core read grant keeps that read's return.
    idle();
    dbg_halt = 1;
    expect_gnt("halt after grant", P_NONE);
    tick();
    dbg_halt = 0;
    tick();

    // Reset arriving at the edge ending a MEM read grant cancels its return.
    mem_req = 1; mem_we = 0; mem_addr = 8'h10;
    expect_gnt("mid-read grant", P_MEM);
    #3;
    rst = 1;
    @(posedge clk);
    #2;
    check("mid-read mem_rvalid", {31'd0, mem_rvalid}, 32'd0);
    idle();
    rst = 0;
    tick();
    tick();
    tick();

    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nnrv_mem_arb.md
# nnrv_mem_arb

Single-port memory arbiter for the nnrv core. Shares one single-port, registered-read RAM between three requesters: instruction fetch (IF), the memory stage (MEM) and a debug/program loader (DBG). It replaces the multi-port RAM arrangement so the core maps onto one block-RAM port. Arbitration is fixed-priority with a starvation guard for IF and a debug halt that freezes core traffic.

## Interface
Parameters:
- ADDR_WIDTH, 8, word address width
- XLEN, 32, data width
- STARVE_MAX, 4, consecutive IF denials before IF is promoted above MEM (range 1..255)

Ports:
- i_clk  in  1  clock; all logic is on the rising edge
- i_rst  in  1  reset; **synchronous, active-high**
- i_if_req, i_mem_req, i_dbg_req  in  1 each  request; held with its command until granted
- i_mem_we, i_dbg_we  in  1 each  1 = write, 0 = read (IF is read-only)
- i_if_addr, i_mem_addr, i_dbg_addr  in  ADDR_WIDTH each  word address
- i_if_mask, i_mem_mask, i_dbg_mask  in  4 each  byte enables
- i_mem_wdata, i_dbg_wdata  in  XLEN each  write data
- i_dbg_halt  in  1  blocks all IF and MEM grants while high
- o_if_gnt, o_mem_gnt, o_dbg_gnt  out  1 each  command accepted this cycle (combinational)
- o_if_rvalid, o_mem_rvalid, o_dbg_rvalid  out  1 each  read data valid for that port (registered)
- o_rdata  out  XLEN  read data broadcast to all ports; qualify with rvalid
- o_ram_en, o_ram_we  out  1 each  RAM access enable / write enable
- o_ram_addr  out  ADDR_WIDTH  RAM address
- o_ram_mask  out  4  RAM byte enables
- o_ram_wdata  out  XLEN  RAM write data
- i_ram_rdata  in  XLEN  RAM read data, valid one cycle after a read command

## Operation
- Each cycle at most one grant; the granted port's command drives the RAM directly in the same cycle (o_ram_en = any grant).
- Priority: DBG > MEM > IF by default. When the starve counter equals STARVE_MAX, order becomes DBG > IF > MEM.
- i_dbg_halt = 1: o_if_gnt = o_mem_gnt = 0 regardless of request; DBG served normally.
- While i_rst = 1 all grants and o_ram_en are forced 0.
- No grant: o_ram_en = 0, o_ram_we = 0; address/mask/wdata are don't-care (drive zero).
- Starve counter (8 bits, saturating at STARVE_MAX): +1 each cycle i_if_req = 1 and o_if_gnt = 0; cleared when IF is granted or i_if_req = 0; held (not incremented) while i_dbg_halt = 1; cleared by reset.
- Read tracking: a 2-bit registered tag records which port (none/IF/MEM/DBG) issued a read in cycle N; in cycle N+1 only that port's rvalid is 1. Writes produce no rvalid.
- o_rdata = i_ram_rdata (pass-through, no extra register).
- Requests deasserted before grant are dropped without side effects.

## Timing
- Grant latency: 0 cycles (gnt in the same cycle as req when the port wins).
- Read latency: rvalid and data exactly 1 cycle after gnt; fully pipelined, one read per cycle sustained; back-to-back reads from different ports return in grant order.
- Write: committed by the RAM at the edge ending the grant cycle; a read of the same address granted the next cycle returns the new data.
- Reset values: all rvalid 0, read tag none, starve counter 0; all gnt and o_ram_en 0 during reset.
- Reset mid-read: read granted in cycle N, i_rst sampled high at the edge ending N produces no rvalid in N+1.
- Halt asserted in the cycle after a core read grant does not suppress that read's rvalid.

## Test plan
- Reset: hold i_rst 3 cycles with all reqs high -> all gnt, rvalid and o_ram_en 0; after release, DBG granted first cycle.
- IF solo read: RAM[0x10] = 0xDEADBEEF, i_if_req addr 0x10 -> o_if_gnt same cycle, o_if_rvalid = 1 with o_rdata = 0xDEADBEEF next cycle, other rvalids 0.
- Starvation, STARVE_MAX = 4: IF and MEM request continuously -> MEM granted cycles 0-3, IF granted cycle 4, MEM cycles 5-8, IF cycle 9 (counter cleared each IF grant).
- DBG priority: DBG writes 0x12345678 to 0x28 mask 0xF while IF and MEM request -> DBG granted; next cycle IF reads 0x28 -> rdata 0x12345678. Mask 0x1 write of 0xAB -> only byte 0 changes.
- Halt: i_dbg_halt = 1 for 10 cycles with IF and MEM requesting -> no core grants, starve counter stays 0; DBG read served; halt released -> MEM granted that same cycle.
- Reset mid-read: MEM read granted cycle N, i_rst high at edge ending N -> o_mem_rvalid 0 in N+1.
